prog_loader: RTL
================

# prog_loader

Program-memory loader for the 4-bit microprocessor: the writer side of the 4096 x 8 program store that the fetch path reads. It accepts a framed byte stream over a valid/ready handshake and checks its length and checksum. It writes each payload byte to consecutive program addresses starting at 0x000, and holds the processor in reset until a good image has been loaded.

## Interface
- `TIMEOUT`, default 1023: stall limit, in consecutive cycles without `in_valid` while busy; 0 disables the timeout.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; sampled only in IDLE, DONE or ERR.
- `in_valid` in 1: `in_data` is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle; a byte transfers when `in_valid` and `in_ready` are both 1.
- `mem_we` out 1: program-memory write strobe, one cycle per byte.
- `mem_addr` out 12: write address.
- `mem_wdata` out 8: write data.
- `cpu_hold` out 1: active-high hold for the processor's reset; 0 only in DONE.
- `done` out 1: image loaded and verified.
- `error` out 1: load failed.
- `err_code` out 2: failure cause. 01 = bad header, 10 = checksum mismatch, 11 = timeout.

## Operation
- Frame format: LEN_HI, LEN_LO, N payload bytes, CSUM.
  - LEN_HI[7:4] must be 0; LEN_HI[3:0] gives L[11:8]. LEN_LO gives L[7:0].
  - N = L + 1, so N ranges from 1 to 4096.
  - CSUM is valid when (sum of the N payload bytes + CSUM) mod 256 = 0x00.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE:
  - `start`=1 moves to LEN_HI.
  - Entering LEN_HI clears the address counter, byte counter, running sum, timeout counter and `err_code`.
- LEN_HI, on transfer:
  - If `in_data[7:4]` is not 0, go to ERR with code 01.
  - Otherwise store L[11:8] and go to LEN_LO.
- LEN_LO, on transfer: store L[7:0] and go to DATA.
- DATA, on each transfer:
  - Register the byte for writing at the current address.
  - Add the byte to the 8-bit running sum, wrapping modulo 256.
  - Increment the address.
  - After the transfer whose byte count equals L, go to CSUM.
- CSUM, on transfer:
  - If (sum + byte) mod 256 = 0, go to DONE.
  - Otherwise go to ERR with code 10.
- DONE and ERR are sticky.
  - `start`=1 restarts the load: go to LEN_HI.
  - `start` in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- Timeout, in LEN_HI, LEN_LO, DATA and CSUM:
  - A counter increments each cycle that `in_valid`=0.
  - It clears on any transfer.
  - When it reaches `TIMEOUT` (and `TIMEOUT` is not 0), go to ERR with code 11.
- Address arithmetic: 12-bit. The highest address written is L, which is at most 0xFFF, so the address never wraps within a frame.
- Writes already issued are not undone on error.

## Timing
- `in_ready` is decoded combinationally from state: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 elsewhere.
- `mem_we`, `mem_addr` and `mem_wdata` are registered:
  - They are valid in the cycle after a DATA transfer.
  - `mem_we` is 1 for exactly that cycle.
  - Back-to-back transfers give back-to-back writes.
- The write for the last payload byte occurs in the first cycle of CSUM.
- `done`, `error` and `cpu_hold` are registered outputs of the state. `done` rises in the cycle after the CSUM transfer; `cpu_hold` falls in that same cycle.
- The ERR transition happens at the clock edge of the failing transfer, or at the edge of the `TIMEOUT`-th idle cycle.
- Reset (`reset`=0), asynchronous and also effective mid-frame:
  - Return to IDLE.
  - `in_ready`=0, `mem_we`=0, `mem_addr`=0x000, `mem_wdata`=0x00.
  - `cpu_hold`=1, `done`=0, `error`=0, `err_code`=00.
  - No write strobe is produced after reset is asserted.

## Test plan
- Good 3-byte load: start, then stream 00 02 2A 5B 10 6B, all back-to-back. Required: writes 0x000=2A, 0x001=5B, 0x002=10, each `mem_we` one cycle wide. Then `done`=1, `cpu_hold`=0, `error`=0.
- Bad checksum: same frame with CSUM 6C. Required: the 3 writes still occur, then `error`=1, `err_code`=10, `cpu_hold`=1. A following `start` plus the good frame ends in DONE.
- Bad header: LEN_HI=10. Required: ERR with `err_code`=01 after that byte, no `mem_we`, `in_ready`=0 afterwards.
- Backpressure and timeout, with `TIMEOUT`=8:
  - Random `in_valid` gaps of 7 cycles or fewer: the load completes correctly.
  - A gap of 8 cycles in DATA: ERR with `err_code`=11.
- Full image: header 0F FF, payload bytes equal to addr[7:0], CSUM 00. Required: 4096 writes, the last at 0xFFF with data FF, then DONE.
- Reset mid-DATA: assert `reset`=0 after 5 payload bytes. Required: all outputs at their reset values immediately, no further writes. Restart with the good 3-byte frame and it succeeds.

Source files
------------

// File: rtl/prog_loader.sv
// Program-memory loader: receives a framed, checksummed byte stream and writes
// the payload into the 4096 x 8 program store, holding the CPU until a good image lands.
module prog_loader #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ERR_HEADER  = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [11:0]   len;
  // The write address doubles as the payload byte count: both start at 0 and
  // advance together on every DATA transfer.
  logic [11:0]   addr_cnt;
  logic [7:0]    sum;
  logic [TW-1:0] timer;

  logic          xfer;
  logic          timed_out;
  logic [7:0]    csum_total;

  assign in_ready   = (state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM});
  assign xfer       = in_valid && in_ready;
  assign timed_out  = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
  assign csum_total = sum + in_data;

  // NOTE: every register here uses non-blocking assignment so all state and
  // registered outputs update together from the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      len       <= '0;
      addr_cnt  <= '0;
      sum       <= '0;
      timer     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_HI;
            addr_cnt <= '0;
            sum      <= '0;
            timer    <= '0;
            err_code <= '0;
            error    <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end

        default: begin
          if (xfer) begin
            timer <= '0;
            case (state)
              S_LEN_HI: begin
                if (in_data[7:4] != 4'h0) begin
                  state    <= S_ERR;
                  error    <= 1'b1;
                  err_code <= ERR_HEADER;
                end else begin
                  len[11:8] <= in_data[3:0];
                  state     <= S_LEN_LO;
                end
              end
              S_LEN_LO: begin
                len[7:0] <= in_data;
                state    <= S_DATA;
              end
              S_DATA: begin
                mem_we    <= 1'b1;
                mem_addr  <= addr_cnt;
                mem_wdata <= in_data;
                sum       <= csum_total;
                addr_cnt  <= addr_cnt + 12'd1;
                if (addr_cnt == len) state <= S_CSUM;
              end
              default: begin
                if (csum_total == 8'h00) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                end else begin
                  state    <= S_ERR;
                  error    <= 1'b1;
                  err_code <= ERR_CSUM;
                end
              end
            endcase
          end else if (timed_out) begin
            state    <= S_ERR;
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
